spi_master_bfm: RTL
===================

Name: spi_master_bfm

Overview:
- Synthesizable SPI mode-0 master that plays the Raspberry Pi end of the link into the DE0-Nano SPI slave.
- Used in simulation benches to drive word transfers into the processor's SPI peripheral.
- Also usable on-FPGA as a loopback or bring-up master.
- Full-duplex, MSB first. Serial clock is derived from the system clock by a programmable divider.

Parameters:
- WIDTH, 16, bits per transfer (>=2).
- CLK_DIV, 2, clk cycles per sclk half-period (>=1).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high.
- start  in  1  request transfer; sampled only when busy=0.
- tx_data  in  WIDTH  word to send; latched on accepted start.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse at end of transfer.
- rx_data  out  WIDTH  word received; updated only in the done cycle.
- spi_cs_n  out  1  chip select, active-low.
- spi_sclk  out  1  serial clock, CPOL=0.
- spi_mosi  out  1  master out.
- spi_miso  in  1  master in.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, rx_data=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0. Reset mid-transfer aborts; outputs take reset values at the next edge; no done is produced.
- Outputs are all registered. busy=1 iff state!=IDLE. Counter div_cnt counts 0..CLK_DIV-1. Bit counter counts 0..WIDTH-1.
- IDLE:
  - start=1 at edge T0: latch tx_data into shift_tx, clear shift_rx, go to SETUP.
  - At T0+1: spi_cs_n=0, spi_mosi=tx_data[WIDTH-1], busy=1.
- SETUP: hold CLK_DIV cycles with sclk=0, then go to HIGH.
- HIGH:
  - On the entry edge: sclk→1, and spi_miso is sampled into shift_rx LSB, shifting left.
  - Hold CLK_DIV cycles, then go to LOW.
- LOW:
  - On the entry edge: sclk→0.
  - If bits remain: spi_mosi takes the next bit (MSB first). Hold CLK_DIV cycles, then HIGH.
  - After the WIDTH-th bit: spi_mosi holds the last bit; go to HOLD.
- HOLD: cs_n stays 0 and sclk stays 0 for CLK_DIV cycles.
- End of HOLD, single edge: spi_cs_n→1, done→1 (one cycle), rx_data←shift_rx, busy→0, state→IDLE. spi_mosi→0.
- Latency: cs_n is low for exactly 2*CLK_DIV*(WIDTH+1) cycles. done asserts at T0+1+2*CLK_DIV*(WIDTH+1).
- Exactly WIDTH rising sclk edges per transfer. sclk duty is 50%. No sclk edge while cs_n=1.
- Start handling:
  - start while busy=1 is ignored; it is not queued.
  - start during the done cycle is accepted, since busy=0. cs_n is then high for exactly 1 cycle between transfers.
- tx_data changes after acceptance have no effect on the current transfer.
- rx_data holds its value between done pulses.

Test Plan:
- Loopback (spi_miso=spi_mosi), WIDTH=16, CLK_DIV=2, tx 0xA5C3 -> rx_data=0xA5C3 at done.
  - done at T0+69; cs_n low 68 cycles; 16 sclk rises.
- Slave model shifting out 0x3C71 on falling sclk, with 0x1234 captured from MOSI on rising sclk -> rx_data=0x3C71; model holds 0x1234.
- Back-to-back: start held high with tx 0x0001 then 0x8000 -> two transfers; cs_n high exactly 1 cycle between them; rx_data matches each in loopback.
- start pulses during a busy transfer -> ignored; exactly one done pulse; busy stays contiguous.
- reset asserted after the 5th sclk rise -> next cycle cs_n=1, sclk=0, busy=0, done=0, rx_data=0.
  - A new start then completes a normal transfer.
- CLK_DIV=1, WIDTH=8, loopback 0x5A -> done at T0+19; sclk toggles every clk cycle while active; rx_data=0x5A.

Source files
------------

// File: rtl/spi_master_bfm.sv
// SPI mode-0 master (CPOL=0, CPHA=0), full duplex, MSB first.
// Plays the host end of the link into the DE0-Nano SPI slave. It is used in
// simulation benches to drive word transfers, and on the FPGA as a loopback or
// bring-up master. The serial clock half-period is CLK_DIV system clocks.
//
// Frame timeline, one segment = CLK_DIV clocks:
//   SETUP | HIGH LOW | HIGH LOW | ... (WIDTH pairs) | HOLD
// cs_n is low for 2*CLK_DIV*(WIDTH+1) clocks. MISO is sampled on every
// rising sclk edge. MOSI advances on every falling edge except the last one.
module spi_master_bfm #(
   parameter int WIDTH   = 16,
   parameter int CLK_DIV = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] tx_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] rx_data,
   output logic             spi_cs_n,
   output logic             spi_sclk,
   output logic             spi_mosi,
   input  logic             spi_miso
);

   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int BIT_W = $clog2(WIDTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_HIGH,
      S_LOW,
      S_HOLD
   } state_t;

   state_t           r_state;
   logic [DIV_W-1:0] r_div_cnt;
   logic [BIT_W-1:0] r_bit_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_cs_n;
   logic             r_sclk;
   logic             r_mosi;
   logic [WIDTH-1:0] r_rx_data;
   logic [WIDTH-1:0] r_shift_tx;
   logic [WIDTH-1:0] r_shift_rx;

   logic             w_div_last;
   logic             w_bit_last;
   logic             w_accept;
   logic             w_sample;
   logic             w_advance;

   // The last clock of the current segment.
   assign w_div_last = (r_div_cnt == DIV_W'(CLK_DIV - 1));
   // The bit in flight is the final bit of the word.
   assign w_bit_last = (r_bit_cnt == BIT_W'(WIDTH - 1));
   // A start is honoured only from IDLE. The done cycle is IDLE, so a start
   // held high chains transfers with a single-clock cs_n gap.
   assign w_accept   = (r_state == S_IDLE) && start;
   // Edges that enter HIGH: sclk rises here, so MISO is captured.
   assign w_sample   = w_div_last &&
                       ((r_state == S_SETUP) || ((r_state == S_LOW) && !w_bit_last));
   // Edges that leave HIGH while bits remain: MOSI moves to the next bit.
   assign w_advance  = w_div_last && (r_state == S_HIGH) && !w_bit_last;

   assign busy     = r_busy;
   assign done     = r_done;
   assign rx_data  = r_rx_data;
   assign spi_cs_n = r_cs_n;
   assign spi_sclk = r_sclk;
   assign spi_mosi = r_mosi;

   // Datapath shift registers. These are not reset, because every accepted start reloads them.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_shift_tx <= tx_data;
      end else if (w_advance) begin
         r_shift_tx <= {r_shift_tx[WIDTH-2:0], 1'b0};
      end

      if (w_accept) begin
         r_shift_rx <= '0;
      end else if (w_sample) begin
         r_shift_rx <= {r_shift_rx[WIDTH-2:0], spi_miso};
      end
   end

   // Transfer sequencer with registered pin outputs. A reset aborts any frame without a done pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_rx_data <= '0;
         r_cs_n    <= 1'b1;
         r_sclk    <= 1'b0;
         r_mosi    <= 1'b0;
      end else begin
         r_done <= 1'b0;

         // Every non-idle state lasts exactly CLK_DIV clocks.
         if (r_state != S_IDLE) begin
            r_div_cnt <= w_div_last ? '0 : r_div_cnt + 1'b1;
         end

         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state   <= S_SETUP;
                  r_busy    <= 1'b1;
                  r_cs_n    <= 1'b0;
                  r_mosi    <= tx_data[WIDTH-1];
                  r_div_cnt <= '0;
                  r_bit_cnt <= '0;
               end
            end

            S_SETUP: begin
               if (w_div_last) begin
                  r_state <= S_HIGH;
                  r_sclk  <= 1'b1;
               end
            end

            S_HIGH: begin
               if (w_div_last) begin
                  r_state <= S_LOW;
                  r_sclk  <= 1'b0;
                  // After the final bit, MOSI keeps that bit until the end of the frame.
                  if (!w_bit_last) begin
                     r_mosi <= r_shift_tx[WIDTH-2];
                  end
               end
            end

            S_LOW: begin
               if (w_div_last) begin
                  if (w_bit_last) begin
                     r_state <= S_HOLD;
                  end else begin
                     r_state   <= S_HIGH;
                     r_sclk    <= 1'b1;
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                  end
               end
            end

            S_HOLD: begin
               if (w_div_last) begin
                  r_state   <= S_IDLE;
                  r_busy    <= 1'b0;
                  r_cs_n    <= 1'b1;
                  r_done    <= 1'b1;
                  r_rx_data <= r_shift_rx;
                  r_mosi    <= 1'b0;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
